// File: rtl/mem_responder.sv
// Bus target for the core's memory interface: word RAM window, programmable wait states, READYN handshake.
// Optional macro RESP_BUSERR_EN: out-of-window requests complete at once with BUSERRN low and DOUT 16'hFFFF.
module mem_responder #(
    parameter int unsigned ADDR_BITS   = 10,
    parameter logic [15:0] BASE_ADDR   = 16'h0000,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        CLK,
    input  logic        RESETN,
    input  logic [15:0] ABUS,
    input  logic [15:0] DIN,
    output logic [15:0] DOUT,
    input  logic        RD_WRN,
    input  logic        MREQN,
    output logic        READYN,
`ifdef RESP_BUSERR_EN
    output logic        BUSERRN,
`endif
    output logic        SELECTED
);
    localparam int unsigned DEPTH = 2 ** ADDR_BITS;
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] WS_INIT = CNT_W'(WAIT_STATES);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ADDR_BITS-1:0] cap_idx;
    logic                 cap_rd;
    logic [15:0]          cap_din;
    logic                 cap_en;
    logic                 ram_we;
    logic                 hit_c;
    logic                 readyn_d;
    logic                 sel_d;
    logic [15:0]          dout_d;
`ifdef RESP_BUSERR_EN
    logic                 buserrn_d;
`endif

    logic [15:0] ram [DEPTH];

    assign hit_c = (ABUS >> ADDR_BITS) == (BASE_ADDR >> ADDR_BITS);

    // Next-state and next-output logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cap_en   = 1'b0;
        ram_we   = 1'b0;
        readyn_d = READYN;
        sel_d    = SELECTED;
        dout_d   = DOUT;
`ifdef RESP_BUSERR_EN
        buserrn_d = BUSERRN;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!MREQN) begin
                    if (hit_c) begin
                        cap_en = 1'b1;
                        sel_d  = 1'b1;
                        if (WAIT_STATES == 0) begin
                            state_d = ST_ACCESS;
                        end else begin
                            state_d = ST_WAIT;
                            cnt_d   = WS_INIT;
                        end
                    end
`ifdef RESP_BUSERR_EN
                    else begin
                        state_d   = ST_DONE;
                        readyn_d  = 1'b0;
                        buserrn_d = 1'b0;
                        dout_d    = 16'hFFFF;
                    end
`endif
                end
            end
            ST_WAIT: begin
                // Releasing MREQN before the access abandons the request
                if (MREQN) begin
                    state_d = ST_IDLE;
                    sel_d   = 1'b0;
                    cnt_d   = '0;
                end else if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_ACCESS;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_ACCESS: begin
                state_d  = ST_DONE;
                readyn_d = 1'b0;
                if (cap_rd) begin
                    dout_d = ram[cap_idx];
                end else begin
                    ram_we = 1'b1;
                    dout_d = 16'h0000;
                end
            end
            ST_DONE: begin
                if (MREQN) begin
                    state_d  = ST_IDLE;
                    readyn_d = 1'b1;
                    sel_d    = 1'b0;
                    dout_d   = 16'h0000;
`ifdef RESP_BUSERR_EN
                    buserrn_d = 1'b1;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            READYN   <= 1'b1;
            SELECTED <= 1'b0;
            DOUT     <= 16'h0000;
`ifdef RESP_BUSERR_EN
            BUSERRN  <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            READYN   <= readyn_d;
            SELECTED <= sel_d;
            DOUT     <= dout_d;
`ifdef RESP_BUSERR_EN
            BUSERRN  <= buserrn_d;
`endif
        end
    end

    // Request capture; later bus changes are ignored
    always_ff @(posedge CLK) begin
        if (cap_en) begin
            cap_idx <= ABUS[ADDR_BITS-1:0];
            cap_rd  <= RD_WRN;
            cap_din <= DIN;
        end
    end

    // RAM keeps its contents across reset; a reset edge blocks a pending write
    always_ff @(posedge CLK) begin
        if (ram_we && RESETN) begin
            ram[cap_idx] <= cap_din;
        end
    end

    ws_range_a: assert property (@(posedge CLK) WAIT_STATES <= 15)
        else $error("mem_responder: WAIT_STATES must be in 0..15");

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench: three responders (0, 1 and 3 wait states) on one shared bus,
// checked against a request-age reference model, a directed vector table and corner sequences.
module tb_mem_responder;
    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        RESETN = 1'b0;
    logic        RD_WRN = 1'b1;
    logic        MREQN  = 1'b1;
    logic [15:0] ABUS   = 16'h0000;
    logic [15:0] DIN    = 16'h0000;
    logic [2:0]  rdy;
    logic [2:0]  sel;
    logic [15:0] dout_o [3];
`ifdef RESP_BUSERR_EN
    logic [2:0]  berr;
`endif

    mem_responder #(.ADDR_BITS(10), .BASE_ADDR(16'h0000), .WAIT_STATES(0)) u_ws0 (
        .CLK(CLK), .RESETN(RESETN), .ABUS(ABUS), .DIN(DIN), .DOUT(dout_o[0]),
        .RD_WRN(RD_WRN), .MREQN(MREQN), .READYN(rdy[0]),
`ifdef RESP_BUSERR_EN
        .BUSERRN(berr[0]),
`endif
        .SELECTED(sel[0]));
    mem_responder #(.ADDR_BITS(10), .BASE_ADDR(16'h0000), .WAIT_STATES(1)) u_ws1 (
        .CLK(CLK), .RESETN(RESETN), .ABUS(ABUS), .DIN(DIN), .DOUT(dout_o[1]),
        .RD_WRN(RD_WRN), .MREQN(MREQN), .READYN(rdy[1]),
`ifdef RESP_BUSERR_EN
        .BUSERRN(berr[1]),
`endif
        .SELECTED(sel[1]));
    mem_responder #(.ADDR_BITS(10), .BASE_ADDR(16'h0000), .WAIT_STATES(3)) u_ws3 (
        .CLK(CLK), .RESETN(RESETN), .ABUS(ABUS), .DIN(DIN), .DOUT(dout_o[2]),
        .RD_WRN(RD_WRN), .MREQN(MREQN), .READYN(rdy[2]),
`ifdef RESP_BUSERR_EN
        .BUSERRN(berr[2]),
`endif
        .SELECTED(sel[2]));

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: a request completes when its age since capture exceeds the wait count
    int unsigned ws [3] = '{0, 1, 3};
    logic [15:0] mm [3][1024];
    bit          mk [3][1024];
    bit          busy [3];
    bit          done_m [3];
    bit          m_dk [3];
    int          age [3];
    logic        m_rdy [3];
    logic        m_sel [3];
    logic        m_berr [3];
    logic [15:0] m_dout [3];
    logic [9:0]  c_idx [3];
    logic        c_rd [3];
    logic [15:0] c_din [3];

    typedef struct {
        logic        rstn;
        logic        mreqn;
        logic        rd;
        logic [15:0] abus;
        logic [15:0] din;
        logic        rdy;
        logic [15:0] dout;
        logic        sel;
    } vec_t;
    vec_t tbl [$];

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            if (!RESETN) begin
                busy[i] = 0; done_m[i] = 0; m_rdy[i] = 1'b1; m_sel[i] = 1'b0;
                m_dout[i] = 16'h0000; m_dk[i] = 1; m_berr[i] = 1'b1;
            end else if (done_m[i]) begin
                if (MREQN) begin
                    done_m[i] = 0; m_rdy[i] = 1'b1; m_sel[i] = 1'b0;
                    m_dout[i] = 16'h0000; m_dk[i] = 1; m_berr[i] = 1'b1;
                end
            end else if (busy[i]) begin
                age[i]++;
                if (age[i] > int'(ws[i])) begin
                    busy[i] = 0; done_m[i] = 1; m_rdy[i] = 1'b0;
                    if (c_rd[i]) begin
                        m_dout[i] = mm[i][c_idx[i]]; m_dk[i] = mk[i][c_idx[i]];
                    end else begin
                        mm[i][c_idx[i]] = c_din[i]; mk[i][c_idx[i]] = 1;
                        m_dout[i] = 16'h0000; m_dk[i] = 1;
                    end
                end else if (MREQN) begin
                    busy[i] = 0; m_sel[i] = 1'b0;
                end
            end else if (!MREQN) begin
                if (ABUS < 16'h0400) begin
                    busy[i] = 1; age[i] = 0; m_sel[i] = 1'b1;
                    c_idx[i] = ABUS[9:0]; c_rd[i] = RD_WRN; c_din[i] = DIN;
                end
`ifdef RESP_BUSERR_EN
                else begin
                    done_m[i] = 1; m_rdy[i] = 1'b0; m_berr[i] = 1'b0;
                    m_dout[i] = 16'hFFFF; m_dk[i] = 1;
                end
`endif
            end
        end
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge
    task automatic cycle();
        @(posedge CLK);
        model_step();
        @(negedge CLK);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("model readyn ws%0d", ws[i]), 16'(rdy[i]), 16'(m_rdy[i]));
            check($sformatf("model selected ws%0d", ws[i]), 16'(sel[i]), 16'(m_sel[i]));
            if (m_dk[i]) check($sformatf("model dout ws%0d", ws[i]), dout_o[i], m_dout[i]);
`ifdef RESP_BUSERR_EN
            check($sformatf("model buserrn ws%0d", ws[i]), 16'(berr[i]), 16'(m_berr[i]));
`endif
        end
    endtask

    task automatic bus_op(input logic rd, input logic [15:0] a, input logic [15:0] d,
                          output logic [15:0] q0, output logic [15:0] q1, output logic [15:0] q2);
        int n;
        n = 0;
        MREQN = 1'b0; RD_WRN = rd; ABUS = a; DIN = d;
        do begin
            cycle();
            n++;
        end while (rdy != 3'b000 && n < 20);
        check("bus_op handshake", 16'(rdy), 16'h0000);
        q0 = dout_o[0]; q1 = dout_o[1]; q2 = dout_o[2];
        MREQN = 1'b1;
        cycle();
    endtask

    task automatic add(input logic rs, input logic mq, input logic rd, input logic [15:0] a,
                       input logic [15:0] d, input logic er, input logic [15:0] eo, input logic es);
        vec_t v;
        v.rstn = rs; v.mreqn = mq; v.rd = rd; v.abus = a; v.din = d;
        v.rdy = er; v.dout = eo; v.sel = es;
        tbl.push_back(v);
    endtask

    initial begin
        logic [15:0] q0, q1, q2;
        bit ok;
        int n;
        int run;
        int r;

        // Directed vectors; expectations are for the one-wait-state responder
        add(0, 1, 1, 16'h0000, 16'h0000, 1, 16'h0000, 0);
        add(0, 1, 1, 16'h0000, 16'h0000, 1, 16'h0000, 0);
        add(1, 0, 0, 16'h0005, 16'hBEEF, 1, 16'h0000, 1);
        add(1, 0, 0, 16'h0006, 16'h0000, 1, 16'h0000, 1);
        add(1, 0, 0, 16'h0006, 16'h0000, 0, 16'h0000, 1);
        add(1, 1, 0, 16'h0006, 16'h0000, 1, 16'h0000, 0);
        add(1, 0, 1, 16'h0005, 16'h0000, 1, 16'h0000, 1);
        add(1, 0, 1, 16'h0007, 16'h1234, 1, 16'h0000, 1);
        add(1, 0, 1, 16'h0007, 16'h1234, 0, 16'hBEEF, 1);
        add(1, 0, 1, 16'h0007, 16'h1234, 0, 16'hBEEF, 1);
        add(1, 1, 1, 16'h0007, 16'h1234, 1, 16'h0000, 0);
        add(1, 1, 1, 16'h0000, 16'h0000, 1, 16'h0000, 0);
`ifdef RESP_BUSERR_EN
        add(1, 0, 1, 16'h0800, 16'h0000, 0, 16'hFFFF, 0);
        add(1, 0, 1, 16'h0800, 16'h0000, 0, 16'hFFFF, 0);
`else
        add(1, 0, 1, 16'h0800, 16'h0000, 1, 16'h0000, 0);
        add(1, 0, 1, 16'h0800, 16'h0000, 1, 16'h0000, 0);
`endif
        add(1, 1, 1, 16'h0800, 16'h0000, 1, 16'h0000, 0);
        add(1, 0, 0, 16'h03FF, 16'hCAFE, 1, 16'h0000, 1);
        add(1, 0, 0, 16'h03FF, 16'hCAFE, 1, 16'h0000, 1);
        add(1, 0, 0, 16'h03FF, 16'hCAFE, 0, 16'h0000, 1);
        add(1, 1, 0, 16'h03FF, 16'hCAFE, 1, 16'h0000, 0);
        add(1, 0, 1, 16'h03FF, 16'h0000, 1, 16'h0000, 1);
        add(1, 0, 1, 16'h03FF, 16'h0000, 1, 16'h0000, 1);
        add(1, 0, 1, 16'h03FF, 16'h0000, 0, 16'hCAFE, 1);
        add(1, 1, 1, 16'h03FF, 16'h0000, 1, 16'h0000, 0);

        foreach (tbl[k]) begin
            RESETN = tbl[k].rstn; MREQN = tbl[k].mreqn; RD_WRN = tbl[k].rd;
            ABUS = tbl[k].abus; DIN = tbl[k].din;
            cycle();
            check($sformatf("vec%0d readyn", k), 16'(rdy[1]), 16'(tbl[k].rdy));
            check($sformatf("vec%0d dout", k), dout_o[1], tbl[k].dout);
            check($sformatf("vec%0d selected", k), 16'(sel[1]), 16'(tbl[k].sel));
        end

        // Known contents for every address the later sequences touch
        for (int a = 0; a < 32; a++) bus_op(1'b0, 16'(a), 16'h0000, q0, q1, q2);
        for (int a = 1020; a < 1024; a++) bus_op(1'b0, 16'(a), 16'h0000, q0, q1, q2);

        // Zero wait states: data one edge after capture, slower responders later
        bus_op(1'b0, 16'h0000, 16'h1234, q0, q1, q2);
        MREQN = 1'b0; RD_WRN = 1'b1; ABUS = 16'h0000;
        cycle();
        check("ws0 not early", 16'(rdy[0]), 16'h0001);
        cycle();
        check("ws0 readyn", 16'(rdy[0]), 16'h0000);
        check("ws0 dout", dout_o[0], 16'h1234);
        check("ws1 not early", 16'(rdy[1]), 16'h0001);
        cycle();
        check("ws1 dout", dout_o[1], 16'h1234);
        cycle();
        check("ws3 not early", 16'(rdy[2]), 16'h0001);
        cycle();
        check("ws3 readyn", 16'(rdy[2]), 16'h0000);
        check("ws3 dout", dout_o[2], 16'h1234);
        MREQN = 1'b1;
        cycle();

        // Abort during wait states
        MREQN = 1'b0; RD_WRN = 1'b0; ABUS = 16'h0010; DIN = 16'hAAAA;
        cycle();
        MREQN = 1'b1;
        ok = 1;
        repeat (8) begin
            cycle();
            if (rdy[2] !== 1'b1) ok = 0;
        end
        check("abort readyn stays high", 16'(ok), 16'h0001);
        bus_op(1'b1, 16'h0010, 16'h0000, q0, q1, q2);
        check("abort ws0 committed", q0, 16'hAAAA);
        check("abort ws1 not committed", q1, 16'h0000);
        check("abort ws3 not committed", q2, 16'h0000);

        // Out-of-window request
        MREQN = 1'b0; RD_WRN = 1'b1; ABUS = 16'h0800;
`ifdef RESP_BUSERR_EN
        cycle();
        check("buserr readyn", 16'(rdy), 16'h0000);
        check("buserr buserrn", 16'(berr), 16'h0000);
        check("buserr dout", dout_o[2], 16'hFFFF);
        MREQN = 1'b1;
        cycle();
        check("buserr release", 16'(berr), 16'h0007);
`else
        ok = 1;
        repeat (20) begin
            cycle();
            if (rdy !== 3'b111 || sel !== 3'b000) ok = 0;
        end
        check("out-of-window ignored", 16'(ok), 16'h0001);
        MREQN = 1'b1;
        cycle();
`endif

        // Reset during wait states of a write
        MREQN = 1'b0; RD_WRN = 1'b0; ABUS = 16'h0003; DIN = 16'h5555;
        cycle();
        RESETN = 1'b0;
        cycle();
        check("reset readyn", 16'(rdy), 16'h0007);
        check("reset selected", 16'(sel), 16'h0000);
        check("reset dout", dout_o[2] | dout_o[1] | dout_o[0], 16'h0000);
        RESETN = 1'b1; MREQN = 1'b1;
        cycle();
        bus_op(1'b1, 16'h0003, 16'h0000, q0, q1, q2);
        check("reset write dropped ws0", q0, 16'h0000);
        check("reset write dropped ws3", q2, 16'h0000);

        // Hold in DONE while MREQN stays low
        bus_op(1'b0, 16'h0005, 16'h7E57, q0, q1, q2);
        MREQN = 1'b0; RD_WRN = 1'b1; ABUS = 16'h0005;
        n = 0;
        do begin
            cycle();
            n++;
        end while (rdy != 3'b000 && n < 10);
        check("hold reached done", 16'(rdy), 16'h0000);
        ok = 1;
        repeat (10) begin
            ABUS = 16'($urandom_range(0, 31)); DIN = 16'($urandom); RD_WRN = 1'($urandom);
            cycle();
            if (rdy !== 3'b000 || sel !== 3'b111) ok = 0;
            for (int i = 0; i < 3; i++) if (dout_o[i] !== 16'h7E57) ok = 0;
        end
        check("hold stable", 16'(ok), 16'h0001);
        MREQN = 1'b1;
        cycle();
        check("hold release", 16'(rdy), 16'h0007);

        // Randomised traffic against the model
        run = 0;
        for (int c = 0; c < 3000; c++) begin
            if (run == 0) begin
                MREQN = ~MREQN;
                run = $urandom_range(1, 7);
            end
            run--;
            RESETN = ($urandom_range(0, 99) != 0);
            RD_WRN = 1'($urandom);
            r = $urandom_range(0, 39);
            if (r < 32) ABUS = 16'(r);
            else if (r < 36) ABUS = 16'(1023 - (r - 32));
            else if (r < 38) ABUS = 16'h0400 + 16'(r);
            else ABUS = 16'hFC00;
            DIN = 16'($urandom);
            cycle();
        end
        RESETN = 1'b1; MREQN = 1'b1;
        cycle();
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Bus-side target for the CPU core's memory interface: answers MREQN/RD_WRN/ABUS requests, sinks write data and sources read data.
- Contains a word-addressed on-chip RAM mapped at a fixed base address.
- Programmable wait states.
- Signals completion with an active-low READYN handshake, so the core's fetch/execute sequencer can stall on slow memory.

Parameters:
- ADDR_BITS, 10, RAM depth is 2**ADDR_BITS 16-bit words.
- BASE_ADDR, 16'h0000, window base; must be aligned to 2**ADDR_BITS.
- WAIT_STATES, 1, extra cycles between request capture and access (0..15).

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- RESETN  in  1  synchronous active-low reset, sampled on CLK rising edge.
- ABUS  in  16  word address from core.
- DIN  in  16  write data from core (core's DOUT).
- DOUT  out  16  read data to core (core's DIN).
- RD_WRN  in  1  1 = read, 0 = write.
- MREQN  in  1  active-low memory request.
- READYN  out  1  active-low access-complete.
- SELECTED  out  1  high while a captured in-window request is in progress.

Behaviour:
- Window hit: ABUS[15:ADDR_BITS] == BASE_ADDR[15:ADDR_BITS].
- RAM index: ABUS[ADDR_BITS-1:0].
- Reset (RESETN low at an edge):
  - state <= IDLE, READYN = 1, DOUT = 16'h0000, SELECTED = 0, wait counter = 0.
  - RAM contents are not cleared.
- State machine IDLE / WAIT / ACCESS / DONE:
  - IDLE: edge sampling MREQN = 0 with a window hit captures ABUS, RD_WRN and DIN into internal registers and sets SELECTED = 1.
    - Next state is WAIT with counter = WAIT_STATES, or ACCESS if WAIT_STATES == 0.
    - Out-of-window request: stay IDLE, no response.
  - WAIT: counter decrements each edge; when the counter reaches 1, next state is ACCESS.
    - MREQN sampled high in WAIT aborts the request: back to IDLE, SELECTED = 0, no RAM write.
  - ACCESS (one edge):
    - Read: DOUT <= RAM[captured index].
    - Write: RAM[captured index] <= captured DIN, DOUT stays 16'h0000.
    - READYN <= 0; next state is DONE.
  - DONE: READYN held 0 and DOUT held until an edge samples MREQN = 1.
    - At that edge: READYN <= 1, DOUT <= 0, SELECTED <= 0, state IDLE.
- Latency:
  - Capture at edge E0; READYN low and read data valid after edge E0+1+WAIT_STATES.
  - Write commits at that same edge.
- Back-to-back requests need MREQN high for at least one sampled edge between them, because DONE exits only on MREQN high.
- Address/data changes after capture are ignored; captured values are used.
- Reset asserted mid-operation (any state) returns to IDLE with the reset values. A write not yet at ACCESS is not committed.
- Read-after-write to the same word returns the new data.
- WAIT_STATES above 15 is a configuration error; an assertion fires in simulation.

Optional Feature:
- Macro RESP_BUSERR_EN.
- When defined:
  - Extra output BUSERRN (1 bit, active low, reset 1).
  - An out-of-window request in IDLE goes directly to DONE after one edge with READYN = 0, BUSERRN = 0, DOUT = 16'hFFFF, and no RAM access.
  - BUSERRN returns to 1 together with READYN.
- When not defined:
  - Port absent.
  - Out-of-window requests are ignored; READYN stays 1 and the core will stall.

Test Plan:
- Write then read, WAIT_STATES=1, BASE=0:
  - MREQN=0, RD_WRN=0, ABUS=16'h0005, DIN=16'hBEEF -> READYN low 2 edges after capture; release MREQN -> READYN high.
  - Read 16'h0005 -> DOUT=16'hBEEF, with READYN low 2 edges after capture.
- WAIT_STATES=0, read 16'h0000 after writing 16'h1234 -> READYN low and DOUT=16'h1234 one edge after capture.
- Abort:
  - Write ABUS=16'h0010, DIN=16'hAAAA with WAIT_STATES=3, deassert MREQN after 1 cycle -> READYN never low.
  - Subsequent read of 16'h0010 returns the prior value 16'h0000 (preloaded).
- Out-of-window, ADDR_BITS=10, ABUS=16'h0800:
  - Without macro: READYN stays 1 for 20 cycles.
  - With RESP_BUSERR_EN: READYN=0, BUSERRN=0, DOUT=16'hFFFF one edge after capture.
- Reset mid-WAIT during a write to 16'h0003 (data 16'h5555) -> all outputs at reset values next edge; later read of 16'h0003 is not 16'h5555.
- Hold in DONE: keep MREQN=0 for 10 cycles after READYN low -> READYN and DOUT stable; no second access; SELECTED=1 throughout.
